// File: rtl/gecko_iter_shifter_pkg.sv
// Shared types for the gecko iterative shifter: operation modes, FSM states
// and the command-code decode that folds unused codes onto logical-left.
package gecko_iter_shifter_pkg;

    localparam int TYPE_W   = 3;
    localparam int STRIDE_W = 3;

    typedef enum logic [2:0] {
        SHIFT_LL  = 3'd0,
        SHIFT_RL  = 3'd1,
        SHIFT_RA  = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } gecko_iter_shift_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } gecko_iter_shift_state_t;

    // Codes 5-7 have no mode of their own and behave as a logical left shift.
    function automatic gecko_iter_shift_type_t decode_shift_type(input logic [TYPE_W-1:0] code);
        gecko_iter_shift_type_t t;
        case (code)
            3'd1:    t = SHIFT_RL;
            3'd2:    t = SHIFT_RA;
            3'd3:    t = SHIFT_ROL;
            3'd4:    t = SHIFT_ROR;
            default: t = SHIFT_LL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/gecko_iter_shifter_if.sv
// Command and result handshake bundle of the gecko iterative shifter.
interface gecko_iter_shifter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] cmd_value;
    logic [2:0]            cmd_type;
    logic [SHAMT_W-1:0]    cmd_shift;
    logic [2:0]            cmd_stride;
    logic [TAG_WIDTH-1:0]  cmd_tag;
    logic                  result_valid;
    logic                  result_ready;
    logic [DATA_WIDTH-1:0] result_value;
    logic [TAG_WIDTH-1:0]  result_tag;

    modport master (
        output cmd_valid, cmd_value, cmd_type, cmd_shift, cmd_stride, cmd_tag, result_ready,
        input  cmd_ready, result_valid, result_value, result_tag
    );

    modport slave (
        input  cmd_valid, cmd_value, cmd_type, cmd_shift, cmd_stride, cmd_tag, result_ready,
        output cmd_ready, result_valid, result_value, result_tag
    );

endinterface

// File: rtl/gecko_iter_shifter_step.sv
// Combinational single-step shifter: moves value by 0..MAX_STEP positions
// using the fill rule of the selected mode.
module gecko_shift_step
    import gecko_iter_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STEP   = 4,
    localparam int STEP_W    = $clog2(MAX_STEP + 1)
) (
    input  logic [DATA_WIDTH-1:0]  value_i,
    input  gecko_iter_shift_type_t type_i,
    input  logic                   sign_i,
    input  logic [STEP_W-1:0]      step_i,
    output logic [DATA_WIDTH-1:0]  value_o
);

    logic [DATA_WIDTH-1:0] signMask;
    logic [DATA_WIDTH-1:0] rotLeft;
    logic [DATA_WIDTH-1:0] rotRight;

    // A shift by DATA_WIDTH yields zero, so step 0 rotates cleanly to the identity.
    assign signMask = ~({DATA_WIDTH{1'b1}} >> step_i);
    assign rotLeft  = (value_i << step_i) | (value_i >> (DATA_WIDTH - int'(step_i)));
    assign rotRight = (value_i >> step_i) | (value_i << (DATA_WIDTH - int'(step_i)));

    always_comb begin
        value_o = value_i << step_i;
        case (type_i)
            SHIFT_RL:  value_o = value_i >> step_i;
            SHIFT_RA:  value_o = (value_i >> step_i) | (sign_i ? signMask : '0);
            SHIFT_ROL: value_o = rotLeft;
            SHIFT_ROR: value_o = rotRight;
            default:   value_o = value_i << step_i;
        endcase
    end

endmodule

// File: rtl/gecko_iter_shifter.sv
// Iterative barrel-shift execute unit: captures a command, shifts at most
// MAX_STEP positions per cycle, then holds the result until it is taken.
module gecko_iter_shifter
    import gecko_iter_shifter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STEP   = 4,
    parameter int TAG_WIDTH  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    gecko_iter_shifter_if.slave bus
);

    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int STEP_W  = $clog2(MAX_STEP + 1);
    localparam logic [SHAMT_W:0] MAX_STEP_V = (SHAMT_W + 1)'(MAX_STEP);

    gecko_iter_shift_state_t state_q, state_d;
    gecko_iter_shift_type_t  type_q, type_d;
    logic [DATA_WIDTH-1:0]   value_q, value_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [SHAMT_W:0]        remaining_q, remaining_d;
    logic                    sign_q, sign_d;

    logic [SHAMT_W-1:0]      effShift;
    logic [STEP_W-1:0]       stepAmt;
    logic [DATA_WIDTH-1:0]   stepValue;
    logic                    cmdReady;

    // Shifting within the SHAMT_W-wide operand drops the overflow, so large strides give zero.
    assign effShift = bus.cmd_shift << bus.cmd_stride;
    assign stepAmt  = (remaining_q > MAX_STEP_V) ? STEP_W'(MAX_STEP) : remaining_q[STEP_W-1:0];

    gecko_shift_step #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_STEP  (MAX_STEP)
    ) u_step (
        .value_i(value_q),
        .type_i (type_q),
        .sign_i (sign_q),
        .step_i (stepAmt),
        .value_o(stepValue)
    );

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        value_d     = value_q;
        tag_d       = tag_q;
        remaining_d = remaining_q;
        sign_d      = sign_q;
        cmdReady    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.result_ready);

        case (state_q)
            ST_SHIFT: begin
                value_d     = stepValue;
                remaining_d = remaining_q - (SHAMT_W + 1)'(stepAmt);
                if (remaining_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase

        // Acceptance overrides the return to IDLE, giving back-to-back operation.
        if (cmdReady && bus.cmd_valid) begin
            value_d     = bus.cmd_value;
            type_d      = decode_shift_type(bus.cmd_type);
            sign_d      = bus.cmd_value[DATA_WIDTH-1];
            tag_d       = bus.cmd_tag;
            remaining_d = (SHAMT_W + 1)'(effShift);
            state_d     = (effShift == '0) ? ST_DONE : ST_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            type_q      <= SHIFT_LL;
            value_q     <= '0;
            tag_q       <= '0;
            remaining_q <= '0;
            sign_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            value_q     <= value_d;
            tag_q       <= tag_d;
            remaining_q <= remaining_d;
            sign_q      <= sign_d;
        end
    end

    assign bus.cmd_ready    = cmdReady;
    assign bus.result_valid = (state_q == ST_DONE);
    assign bus.result_value = value_q;
    assign bus.result_tag   = tag_q;

endmodule

// File: tb/tb_gecko_iter_shifter.sv
// Directed self-checking bench for gecko_iter_shifter (DATA_WIDTH 32, MAX_STEP 4).
module tb_gecko_iter_shifter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] value;
        logic [4:0]  shift;
        logic [2:0]  stride;
        logic [4:0]  tag;
        logic [31:0] expected;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    gecko_iter_shifter_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

    gecko_iter_shifter #(
        .DATA_WIDTH(32),
        .MAX_STEP  (4),
        .TAG_WIDTH (5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive a command at a negedge, let the next rising edge accept it, then release.
    task automatic applyStimulus(input logic [2:0] typ, input logic [31:0] value,
                                 input logic [4:0] shift, input logic [2:0] stride,
                                 input logic [4:0] tag);
        bus.cmd_type   = typ;
        bus.cmd_value  = value;
        bus.cmd_shift  = shift;
        bus.cmd_stride = stride;
        bus.cmd_tag    = tag;
        bus.cmd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid    = 1'b0;
        bus.result_ready = 1'b0;
    endtask

    // Latency counts the accepting edge as edge 1; -1 means the bound expired.
    task automatic waitResult(output int lat);
        lat = 1;
        while (bus.result_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (bus.result_valid !== 1'b1) lat = -1;
    endtask

    task automatic consumeResult();
        bus.result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready);
        end
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_result_valid: got %b expected 0", bus.result_valid);
        end
        checks++;
        if (bus.result_value !== 32'h0 || bus.result_tag !== 5'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got value %h tag %h expected 0/0",
                     bus.result_value, bus.result_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release: got valid %b ready %b expected 0/1",
                     bus.result_valid, bus.cmd_ready);
        end
    endtask

    task automatic test_shift_modes();
        int lat;
        vecs.delete();
        vecs.push_back('{3'd0, 32'h0000_0001, 5'd5,  3'd0, 5'h01, 32'h0000_0020, 3});
        vecs.push_back('{3'd2, 32'h8000_0000, 5'd31, 3'd0, 5'h02, 32'hFFFF_FFFF, 9});
        vecs.push_back('{3'd1, 32'h8000_0000, 5'd31, 3'd0, 5'h03, 32'h0000_0001, 9});
        vecs.push_back('{3'd4, 32'h0000_00F1, 5'd4,  3'd0, 5'h04, 32'h1000_000F, 2});
        vecs.push_back('{3'd3, 32'h8000_0001, 5'd1,  3'd0, 5'h05, 32'h0000_0003, 2});
        vecs.push_back('{3'd1, 32'hABCD_1234, 5'd1,  3'd3, 5'h06, 32'h00AB_CD12, 3});
        vecs.push_back('{3'd1, 32'hABCD_1234, 5'd1,  3'd5, 5'h07, 32'hABCD_1234, 1});
        vecs.push_back('{3'd7, 32'h0000_0001, 5'd3,  3'd0, 5'h08, 32'h0000_0008, 2});
        vecs.push_back('{3'd2, 32'h7000_0000, 5'd4,  3'd0, 5'h09, 32'h0700_0000, 2});
        vecs.push_back('{3'd3, 32'h1234_5678, 5'd1,  3'd2, 5'h0A, 32'h2345_6781, 2});
        vecs.push_back('{3'd4, 32'h0000_0001, 5'd31, 3'd0, 5'h0B, 32'h0000_0002, 9});
        foreach (vecs[i]) begin
            checks++;
            if (bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mode%0d_ready: got %b expected 1", i, bus.cmd_ready);
            end
            applyStimulus(vecs[i].typ, vecs[i].value, vecs[i].shift, vecs[i].stride, vecs[i].tag);
            waitResult(lat);
            checks++;
            if (lat !== vecs[i].lat) begin
                errors++;
                $display("[TB] FAIL mode%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat);
            end
            checks++;
            if (bus.result_value !== vecs[i].expected) begin
                errors++;
                $display("[TB] FAIL mode%0d_value: got %h expected %h", i,
                         bus.result_value, vecs[i].expected);
            end
            checks++;
            if (bus.result_tag !== vecs[i].tag) begin
                errors++;
                $display("[TB] FAIL mode%0d_tag: got %h expected %h", i, bus.result_tag, vecs[i].tag);
            end
            consumeResult();
            checks++;
            if (bus.result_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL mode%0d_release: got valid %b expected 0", i, bus.result_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        applyStimulus(3'd0, 32'h0000_0003, 5'd2, 3'd0, 5'h05);
        waitResult(lat);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.result_valid !== 1'b1 || bus.result_value !== 32'h0000_000C ||
                bus.result_tag !== 5'h05 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got valid %b value %h tag %h ready %b expected 1/0000000c/05/0",
                         c, bus.result_valid, bus.result_value, bus.result_tag, bus.cmd_ready);
            end
        end
        bus.result_ready = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_ready_follow: got %b expected 1", bus.cmd_ready);
        end
        applyStimulus(3'd4, 32'h0000_0001, 5'd1, 3'd0, 5'h1A);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_shifting: got valid %b ready %b expected 0/0",
                     bus.result_valid, bus.cmd_ready);
        end
        waitResult(lat);
        checks++;
        if (lat !== 2 || bus.result_value !== 32'h8000_0000 || bus.result_tag !== 5'h1A) begin
            errors++;
            $display("[TB] FAIL b2b_result: got lat %0d value %h tag %h expected 2/80000000/1a",
                     lat, bus.result_value, bus.result_tag);
        end
        consumeResult();
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        applyStimulus(3'd2, 32'h8000_0000, 5'd31, 3'd0, 5'h11);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL shift_cmd_ready: got %b expected 0", bus.cmd_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.cmd_ready !== 1'b1 ||
            bus.result_value !== 32'h0 || bus.result_tag !== 5'h0) begin
            errors++;
            $display("[TB] FAIL midshift_reset: got valid %b ready %b value %h tag %h expected 0/1/0/0",
                     bus.result_valid, bus.cmd_ready, bus.result_value, bus.result_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL discarded_op: got valid %b expected 0", bus.result_valid);
        end
        applyStimulus(3'd0, 32'h0000_0001, 5'd5, 3'd0, 5'h03);
        waitResult(lat);
        checks++;
        if (lat !== 3 || bus.result_value !== 32'h0000_0020 || bus.result_tag !== 5'h03) begin
            errors++;
            $display("[TB] FAIL post_reset_op: got lat %0d value %h tag %h expected 3/00000020/03",
                     lat, bus.result_value, bus.result_tag);
        end
        consumeResult();
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_value    = '0;
        bus.cmd_type     = '0;
        bus.cmd_shift    = '0;
        bus.cmd_stride   = '0;
        bus.cmd_tag      = '0;
        bus.result_ready = 1'b0;
        $display("[TB] starting gecko_iter_shifter bench");
        test_reset();
        test_shift_modes();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
